// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: ceil-log2, slice-index width and the IN/OUT width ratio check.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

package fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A single-slice word still needs a one-bit index.
    function automatic int unsigned slice_idx_w(input int unsigned ratio);
        return (ratio <= 1) ? 1 : clog2(ratio);
    endfunction

endpackage

`define FIFO_RATIO_CHECK(IN_W, OUT_W) if (((IN_W) % (OUT_W)) != 0) begin : g_ratio_check $error("IN_WIDTH must be a non-zero multiple of OUT_WIDTH"); end

`endif

// File: rtl/fifo_unpack_slice_mux.sv
// Combinational slice selector: returns slice i_idx of i_word, LSB-first by default,
// MSB-first when FIFO_RD_UNPACK_MSB_FIRST_EN is defined.
module fifo_unpack_slice_mux
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned IDX_W     = slice_idx_w(IN_WIDTH / OUT_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  i_word,
    input  logic [IDX_W-1:0]     i_idx,
    output logic [OUT_WIDTH-1:0] o_slice
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;

    always_comb begin
        o_slice = '0;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (i_idx == IDX_W'(k)) begin
`ifdef FIFO_RD_UNPACK_MSB_FIRST_EN
                o_slice = i_word[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
                o_slice = i_word[k*OUT_WIDTH +: OUT_WIDTH];
`endif
            end
        end
    end

endmodule

// File: rtl/fifo_rd_unpack.sv
// Read-side unpacker for the async FIFO: pops IN_WIDTH words through a 2-word credit window
// and streams OUT_WIDTH slices. FIFO_RD_UNPACK_MSB_FIRST_EN selects MSB-first slice order.
module fifo_rd_unpack
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W = slice_idx_w(RATIO);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    `FIFO_RATIO_CHECK(IN_WIDTH, OUT_WIDTH)

    logic [IN_WIDTH-1:0] r_cur;
    logic [IN_WIDTH-1:0] r_nxt;
    logic                r_cur_v;
    logic                r_nxt_v;
    logic                r_inflight;
    logic [IDX_W-1:0]    r_idx;

    logic                w_slice_last;
    logic                w_transfer;
    logic                w_release;
    logic [1:0]          w_credit;

    assign w_slice_last = (r_idx == IDX_LAST);
    assign w_transfer   = r_cur_v & m_ready;
    assign w_release    = w_transfer & w_slice_last;
    assign w_credit     = 2'(r_cur_v) + 2'(r_nxt_v) + 2'(r_inflight);

    // A full window may still pop when the current word leaves this cycle.
    assign fifo_rd_en = !rst && !fifo_empty &&
                        ((w_credit < 2'd2) || ((w_credit == 2'd2) && w_release));

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_cur_v    <= 1'b0;
            r_nxt_v    <= 1'b0;
            r_inflight <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_transfer) begin
                r_idx <= w_slice_last ? '0 : r_idx + IDX_W'(1);
            end
            if (r_inflight) begin
                if (!r_cur_v || (w_release && !r_nxt_v)) begin
                    r_cur   <= fifo_dout;
                    r_cur_v <= 1'b1;
                end else if (w_release) begin
                    r_cur <= r_nxt;
                    r_nxt <= fifo_dout;
                end else begin
                    r_nxt   <= fifo_dout;
                    r_nxt_v <= 1'b1;
                end
            end else if (w_release) begin
                r_cur   <= r_nxt;
                r_cur_v <= r_nxt_v;
                r_nxt_v <= 1'b0;
            end
        end
    end

    assign m_valid = r_cur_v;
    assign m_last  = r_cur_v & w_slice_last;
    assign busy    = r_cur_v | r_nxt_v | r_inflight;

    fifo_unpack_slice_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .IDX_W     (IDX_W)
    ) u_slice_mux (
        .i_word  (r_cur),
        .i_idx   (r_idx),
        .o_slice (m_data)
    );

endmodule
